// File: rtl/psum_col_collector.sv
// psum_col_collector: south-edge receiver for the MAC array.
// Each column captures its psum word into a private FIFO when its (skewed)
// valid bit is high; once every column holds a word, one aligned row can be
// popped into the registered output.
// Optional build macro: PSUM_RELU_EN clamps negative popped words to zero.
//
// Handshake: o_valid acts as "row available" and rd as "consumer ready";
// a pop happens exactly on an edge where rd & o_valid, and the popped row
// appears on out with a one-cycle out_vld pulse after that edge. rd without
// o_valid is ignored.
module psum_col_collector #(
    parameter int psum_bw   = 16,
    parameter int col       = 8,
    parameter int depth     = 8,
    parameter int depth_log = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         valid,
    input  logic                   rd,
    input  logic                   ovf_clr,
    output logic [psum_bw*col-1:0] out,
    output logic                   out_vld,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   overflow
);

    localparam logic [depth_log:0] full_cnt = (depth_log + 1)'(depth);

    logic [psum_bw-1:0]     mem    [col][depth];
    logic [depth_log-1:0]   wr_ptr [col];
    logic [depth_log-1:0]   rd_ptr [col];
    logic [depth_log:0]     count  [col];

    logic [col-1:0]         nonempty;
    logic [col-1:0]         full;
    logic [col-1:0]         wr_ok;
    logic                   pop;
    logic                   drop;
    logic [psum_bw*col-1:0] head_row;

    // Per-column status derived from the registered counts.
    always_comb begin
        nonempty = '0;
        full     = '0;
        for (int i = 0; i < col; i++) begin
            nonempty[i] = (count[i] != '0);
            full[i]     = (count[i] == full_cnt);
        end
    end

    assign o_valid = &nonempty;
    assign o_full  = |full;
    assign pop     = rd & o_valid;
    // A full column still accepts a word when the same edge pops its head.
    assign wr_ok   = valid & (~full | {col{pop}});
    assign drop    = (|(valid & full)) & ~pop;

    // Head of every column; the optional clamp zeroes negative words.
    always_comb begin
        head_row = '0;
        for (int i = 0; i < col; i++) begin
`ifdef PSUM_RELU_EN
            head_row[i*psum_bw +: psum_bw] =
                mem[i][rd_ptr[i]][psum_bw-1] ? '0 : mem[i][rd_ptr[i]];
`else
            head_row[i*psum_bw +: psum_bw] = mem[i][rd_ptr[i]];
`endif
        end
    end

    // FIFO storage: contents need no reset, only the pointers do.
    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (wr_ok[i]) begin
                mem[i][wr_ptr[i]] <= in[i*psum_bw +: psum_bw];
            end
        end
    end

    // Per-column pointers and occupancy counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < col; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < col; i++) begin
                if (wr_ok[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                case ({wr_ok[i], pop})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Registered output row and its one-cycle strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out     <= '0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= pop;
            if (pop) begin
                out <= head_row;
            end
        end
    end

    // Sticky overflow: a drop on the same edge as ovf_clr keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_psum_col_collector.sv
// Bench for psum_col_collector: directed stimulus, expected rows queued at
// pop time and compared by an independent output monitor.
module tb_psum_col_collector;

    localparam int BW   = 16;
    localparam int COLS = 8;
    localparam int W    = BW * COLS;

    logic            clk = 1'b0;
    logic            reset;
    logic [W-1:0]    in_data;
    logic [COLS-1:0] valid;
    logic            rd;
    logic            ovf_clr;
    logic [W-1:0]    out_data;
    logic            out_vld;
    logic            o_valid;
    logic            o_full;
    logic            overflow;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_q[$];
    logic [W-1:0] last_exp = '0;

    // Clock
    always #5 clk = ~clk;

    psum_col_collector #(
        .psum_bw(BW), .col(COLS), .depth(8), .depth_log(3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in_data),
        .valid   (valid),
        .rd      (rd),
        .ovf_clr (ovf_clr),
        .out     (out_data),
        .out_vld (out_vld),
        .o_valid (o_valid),
        .o_full  (o_full),
        .overflow(overflow)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] mk_row(input logic [BW-1:0] base);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < COLS; j++) r[j*BW +: BW] = base + BW'(j);
        return r;
    endfunction

    // Expected effect of the optional clamp on a popped row.
    function automatic logic [W-1:0] clamp_row(input logic [W-1:0] r);
        logic [W-1:0] c;
        c = r;
`ifdef PSUM_RELU_EN
        for (int j = 0; j < COLS; j++)
            if (r[j*BW + BW - 1]) c[j*BW +: BW] = '0;
`endif
        return c;
    endfunction

    // Monitor: every out_vld pulse must match the oldest expected row.
    always @(negedge clk) begin
        if (out_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_vld actual=%h required=no_row", out_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                last_exp = e;
                check("row_out", out_data, e);
            end
        end
    end

    // Driver tasks: inputs applied at negedge, released just after posedge.
    task automatic write_row(input logic [W-1:0] row);
        @(negedge clk);
        valid   = '1;
        in_data = row;
        if (model_q.size() < 8) model_q.push_back(row);
        @(posedge clk); #1;
        valid = '0;
    endtask

    task automatic pop_row();
        @(negedge clk);
        rd = 1'b1;
        if (model_q.size() > 0) exp_q.push_back(clamp_row(model_q.pop_front()));
        @(posedge clk); #1;
        rd = 1'b0;
    endtask

    task automatic write_pop(input logic [W-1:0] row);
        @(negedge clk);
        valid   = '1;
        in_data = row;
        rd      = 1'b1;
        exp_q.push_back(clamp_row(model_q.pop_front()));
        model_q.push_back(row);
        @(posedge clk); #1;
        valid = '0;
        rd    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] r6;
        logic [W-1:0] e6;

        // Reset
        reset = 1'b1; valid = '0; in_data = '0; rd = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out", out_data, '0);
        check("rst_out_vld", W'(out_vld), '0);
        check("rst_o_valid", W'(o_valid), '0);
        check("rst_o_full", W'(o_full), '0);
        check("rst_overflow", W'(overflow), '0);
        reset = 1'b0;

        // Test 1: skewed column writes, row releases after the last column
        for (int i = 0; i < COLS; i++) begin
            @(negedge clk);
            valid   = COLS'(1) << i;
            in_data = mk_row(16'd1);
            @(posedge clk); #1;
            valid = '0;
            @(negedge clk);
            check("t1_o_valid", W'(o_valid), W'(i == COLS - 1));
        end
        model_q.push_back(mk_row(16'd1));
        pop_row();
        @(negedge clk);
        check("t1_empty_after_pop", W'(o_valid), '0);

        // Test 2: fill, overflow, clear behaviour
        for (int r = 0; r < 8; r++) write_row(mk_row(16'h100 * BW'(r + 1)));
        @(negedge clk);
        check("t2_o_full", W'(o_full), W'(1));
        check("t2_o_valid", W'(o_valid), W'(1));
        check("t2_no_ovf_yet", W'(overflow), '0);
        write_row(mk_row(16'h900));
        @(negedge clk);
        check("t2_overflow", W'(overflow), W'(1));
        @(negedge clk);
        valid = '1; in_data = mk_row(16'h910); ovf_clr = 1'b1;
        @(posedge clk); #1;
        valid = '0; ovf_clr = 1'b0;
        @(negedge clk);
        check("t2_set_wins", W'(overflow), W'(1));
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        check("t2_ovf_clr", W'(overflow), '0);

        // Test 3: write + pop on full columns
        write_pop(mk_row(16'hA00));
        @(negedge clk);
        check("t3_no_overflow", W'(overflow), '0);
        check("t3_still_full", W'(o_full), W'(1));
        for (int r = 0; r < 8; r++) pop_row();
        @(negedge clk);
        check("t3_drained_o_valid", W'(o_valid), '0);
        check("t3_drained_o_full", W'(o_full), '0);

        // Test 4: rd while empty is ignored
        @(negedge clk);
        rd = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_out_vld", W'(out_vld), '0);
            check("t4_out_hold", out_data, last_exp);
        end
        rd = 1'b0;

        // Test 5: async reset mid-cycle discards everything
        for (int r = 0; r < 9; r++) write_row(mk_row(16'h300 + BW'(16 * r)));
        @(negedge clk);
        check("t5_pre_overflow", W'(overflow), W'(1));
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("t5_o_valid", W'(o_valid), '0);
        check("t5_overflow", W'(overflow), '0);
        check("t5_out", out_data, '0);
        check("t5_o_full", W'(o_full), '0);
        model_q.delete();
        @(negedge clk);
        reset = 1'b0;
        write_row(mk_row(16'h050));
        pop_row();
        @(negedge clk);
        check("t5_restart_empty", W'(o_valid), '0);

        // Test 6: negative word with and without the clamp
        r6 = '0;
        r6[0 +: BW]  = 16'hFFF6;
        r6[BW +: BW] = 16'd25;
        e6 = '0;
`ifdef PSUM_RELU_EN
        e6[0 +: BW]  = 16'h0000;
`else
        e6[0 +: BW]  = 16'hFFF6;
`endif
        e6[BW +: BW] = 16'd25;
        write_row(r6);
        pop_row();
        @(negedge clk);
        check("t6_out", out_data, e6);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
